// File: rtl/i2c_target_regs_pkg.sv
// Shared types and bus constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_tgt_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_target_regs_bus_sync.sv
// Brings the asynchronous SCL/SDA lines into the clk domain and turns them
// into single-cycle bus event pulses. All pulses and the delayed line values
// scl_s/sda_s are aligned to the same clock cycle.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta;
  logic scl_sync;
  logic scl_s;
  logic sda_meta;
  logic sda_sync;

  // Two-flop synchronizers, a history stage, and registered edge/START/STOP
  // pulses; flops reset to the idle-high bus level so reset makes no events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta  <= 1'b1;
      scl_sync  <= 1'b1;
      scl_s     <= 1'b1;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      sda_s     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_meta  <= scl;
      scl_sync  <= scl_meta;
      scl_s     <= scl_sync;
      sda_meta  <= sda;
      sda_sync  <= sda_meta;
      sda_s     <= sda_sync;
      scl_rise  <= scl_sync & ~scl_s;
      scl_fall  <= ~scl_sync & scl_s;
      start_det <= scl_sync & scl_s & ~sda_sync & sda_s;
      stop_det  <= scl_sync & scl_s & sda_sync & ~sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bus. The first written byte of a
// transaction is the register pointer, later bytes are register writes with
// auto-increment; reads stream from the pointer until the controller NACKs.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         HOLD_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_drive,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  i2c_tgt_state_e state;
  i2c_tgt_state_e state_next;

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic [3:0] hold_cnt;
  logic       rw_bit;
  logic       ptr_loaded;
  logic       rd_capture;
  logic       drive_val;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // The byte completes with the bit being sampled on this SCL rise.
  assign rx_byte = {rx_shift, sda_s};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state on bus events (START/STOP win over SCL edges) and the SDA
  // level this state wants once the post-fall hold time expires.
  always_comb begin
    state_next = state;
    drive_val  = 1'b1;
    case (state)
      ST_ADDR_ACK, ST_WR_ACK: drive_val = I2C_ACK;
      ST_RD_DATA:             drive_val = tx_shift[7];
      default:                drive_val = 1'b1;
    endcase
    if (start_det) begin
      state_next = ST_ADDR;
    end else if (stop_det) begin
      state_next = ST_IDLE;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR:
          if (bit_cnt == 3'd7)
            state_next = (rx_shift == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: state_next = (rw_bit == I2C_RW_READ) ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:  if (bit_cnt == 3'd7) state_next = ST_WR_ACK;
        ST_WR_ACK:   state_next = ST_WR_DATA;
        ST_RD_DATA:  if (bit_cnt == 3'd7) state_next = ST_RD_ACK;
        ST_RD_ACK:   state_next = (sda_s == I2C_ACK) ? ST_RD_DATA : ST_IGNORE;
        default:     state_next = state;
      endcase
    end
  end

  // Datapath: shift registers, bit counter, SDA hold timer, pointer and
  // register-bus strobes. The pointer advances the cycle after a write strobe
  // so the strobe is presented with the address it writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_drive  <= 1'b1;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= 8'hFF;
      hold_cnt   <= 4'd0;
      rw_bit     <= I2C_RW_WRITE;
      ptr_loaded <= 1'b0;
      rd_capture <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      rd_capture <= reg_rd_en;
      if (rd_capture) tx_shift <= reg_rdata;
      if (reg_wr_en) reg_addr <= reg_addr + 8'd1;

      if (state_next == ST_IDLE || state_next == ST_IGNORE) busy <= 1'b0;
      else if (state == ST_ADDR && state_next == ST_ADDR_ACK) busy <= 1'b1;

      if (start_det || stop_det) begin
        bit_cnt   <= 3'd0;
        hold_cnt  <= 4'd0;
        sda_drive <= 1'b1;
        if (start_det) ptr_loaded <= 1'b0;
      end else begin
        if (scl_fall) begin
          hold_cnt <= 4'(HOLD_CYC);
        end else if (hold_cnt != 4'd0) begin
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) sda_drive <= drive_val;
        end

        if (scl_rise) begin
          case (state)
            ST_ADDR: begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) rw_bit <= sda_s;
            end
            ST_WR_DATA: begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (ptr_loaded) begin
                  reg_wr_en <= 1'b1;
                  reg_wdata <= rx_byte;
                end else begin
                  reg_addr   <= rx_byte;
                  ptr_loaded <= 1'b1;
                end
              end
            end
            ST_ADDR_ACK: begin
              if (rw_bit == I2C_RW_READ) reg_rd_en <= 1'b1;
            end
            ST_RD_DATA: begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
            end
            ST_RD_ACK: begin
              if (sda_s == I2C_ACK) begin
                reg_addr  <= reg_addr + 8'd1;
                reg_rd_en <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: table-driven bus transactions plus
// hand-written abort, reset and SDA hold-time sequences.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int HOLD = 3;
  localparam int Q    = 6;

  typedef enum {OP_START, OP_STOP, OP_WRITE, OP_READ_ACK, OP_READ_NACK} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       exp_ack;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_ctrl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_bus;
  logic       sda_drive;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic       wr_sda_q[$];
  logic [7:0] rd_addr_q[$];
  int low_cycles = 0;
  int busy_cycles = 0;

  int   since = 1000;
  logic prev_drive = 1'b1;
  int   hold_seen = 0;
  int   hold_bad = 0;
  int   hold_high_bad = 0;
  int   hold_bad_since = 0;

  vec_t vecs[$];

  assign sda_bus = sda_ctrl & sda_drive;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .HOLD_CYC(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_ctrl),
    .sda       (sda_bus),
    .sda_drive (sda_drive),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_value(input logic [7:0] a);
    case (a)
      8'h20:   return 8'h5A;
      8'h21:   return 8'hC3;
      default: return ~a;
    endcase
  endfunction

  // Local register file: registered read data, one clk behind reg_rd_en.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= rd_value(reg_addr);
  end

  // Strobe log and activity counters sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) begin
        wr_addr_q.push_back(reg_addr);
        wr_data_q.push_back(reg_wdata);
        wr_sda_q.push_back(sda_drive);
      end
      if (reg_rd_en) rd_addr_q.push_back(reg_addr);
      if (!sda_drive) low_cycles++;
      if (busy) busy_cycles++;
    end
  end

  // SDA hold-time watcher: a change must land HOLD clk after the edge that
  // consumes the fall pulse (HOLD+1 negedges after the pulse is seen) and
  // never while synchronized SCL is high.
  always @(negedge clk) begin
    if (rst) begin
      prev_drive = sda_drive;
      since = 1000;
    end else begin
      if (dut.u_bus_sync.scl_fall) since = 0;
      else if (since < 1000) since++;
      if (sda_drive !== prev_drive) begin
        hold_seen++;
        if (since != HOLD + 1) begin
          hold_bad++;
          hold_bad_since = since;
        end
        if (dut.u_bus_sync.scl_s) hold_high_bad++;
      end
      prev_drive = sda_drive;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    wait_clk(Q); sda_ctrl = b;
    wait_clk(Q); scl_ctrl = 1'b1;
    wait_clk(Q); s = sda_bus;
    wait_clk(Q); scl_ctrl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl_ctrl == 1'b0) begin
      wait_clk(Q); sda_ctrl = 1'b1;
      wait_clk(Q); scl_ctrl = 1'b1;
      wait_clk(Q);
    end
    sda_ctrl = 1'b0;
    wait_clk(Q); scl_ctrl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_ctrl = 1'b0;
    wait_clk(Q); scl_ctrl = 1'b1;
    wait_clk(Q); sda_ctrl = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(data[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_out, output logic [7:0] data);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      data[i] = s;
    end
    bit_cycle(ack_out, s);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic       ack;
    logic [7:0] d;
    case (v.op)
      OP_START: i2c_start();
      OP_STOP:  i2c_stop();
      OP_WRITE: begin
        write_byte(v.data, ack);
        checkOutput($sformatf("v%0d_ack", idx), 32'(ack), 32'(v.exp_ack));
      end
      OP_READ_ACK, OP_READ_NACK: begin
        read_byte(v.op == OP_READ_NACK, d);
        checkOutput($sformatf("v%0d_rdata", idx), 32'(d), 32'(v.data));
      end
      default: ;
    endcase
    checkOutput($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.exp_busy));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) applyStimulus(vecs[i], i);
  endtask

  initial begin
    int   w0, r0, lo0, b0, i_wr, i_rd, i_mm, i_wrap, i_end;
    logic s;
    logic [7:0] addr_rd;
    int   waited;

    // Write with pointer
    i_wr = vecs.size();
    vecs.push_back('{OP_START, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{OP_WRITE, 8'hA0, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE, 8'h10, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE, 8'hA5, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE, 8'h3C, 1'b0, 1'b1});
    vecs.push_back('{OP_STOP,  8'h00, 1'b0, 1'b0});
    // Read after repeated start
    i_rd = vecs.size();
    vecs.push_back('{OP_START,     8'h00, 1'b0, 1'b0});
    vecs.push_back('{OP_WRITE,     8'hA0, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE,     8'h20, 1'b0, 1'b1});
    vecs.push_back('{OP_START,     8'h00, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE,     8'hA1, 1'b0, 1'b1});
    vecs.push_back('{OP_READ_ACK,  8'h5A, 1'b0, 1'b1});
    vecs.push_back('{OP_READ_NACK, 8'hC3, 1'b0, 1'b0});
    vecs.push_back('{OP_STOP,      8'h00, 1'b0, 1'b0});
    // Address mismatch
    i_mm = vecs.size();
    vecs.push_back('{OP_START, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{OP_WRITE, 8'hA2, 1'b1, 1'b0});
    vecs.push_back('{OP_WRITE, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{OP_STOP,  8'h00, 1'b0, 1'b0});
    // Pointer wrap
    i_wrap = vecs.size();
    vecs.push_back('{OP_START, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{OP_WRITE, 8'hA0, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE, 8'h11, 1'b0, 1'b1});
    vecs.push_back('{OP_WRITE, 8'h22, 1'b0, 1'b1});
    vecs.push_back('{OP_STOP,  8'h00, 1'b0, 1'b0});
    i_end = vecs.size();

    wait_clk(4);
    rst = 1'b0;
    wait_clk(6);
    checkOutput("reset_sda_drive", 32'(sda_drive), 32'd1);
    checkOutput("reset_reg_addr",  32'(reg_addr),  32'h00);
    checkOutput("reset_reg_wdata", 32'(reg_wdata), 32'h00);
    checkOutput("reset_wr_en",     32'(reg_wr_en), 32'd0);
    checkOutput("reset_rd_en",     32'(reg_rd_en), 32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);

    w0 = wr_addr_q.size();
    run_range(i_wr, i_rd);
    checkOutput("wr_count", 32'(wr_addr_q.size() - w0), 32'd2);
    if (wr_addr_q.size() - w0 == 2) begin
      checkOutput("wr0_addr", 32'(wr_addr_q[w0]),     32'h10);
      checkOutput("wr0_data", 32'(wr_data_q[w0]),     32'hA5);
      checkOutput("wr1_addr", 32'(wr_addr_q[w0 + 1]), 32'h11);
      checkOutput("wr1_data", 32'(wr_data_q[w0 + 1]), 32'h3C);
      checkOutput("wr0_before_ack", 32'(wr_sda_q[w0]), 32'd1);
    end
    checkOutput("wr_final_addr", 32'(reg_addr), 32'h12);

    w0 = wr_addr_q.size();
    r0 = rd_addr_q.size();
    run_range(i_rd, i_mm);
    checkOutput("rd_count", 32'(rd_addr_q.size() - r0), 32'd2);
    if (rd_addr_q.size() - r0 == 2) begin
      checkOutput("rd0_addr", 32'(rd_addr_q[r0]),     32'h20);
      checkOutput("rd1_addr", 32'(rd_addr_q[r0 + 1]), 32'h21);
    end
    checkOutput("rd_no_writes",  32'(wr_addr_q.size() - w0), 32'd0);
    checkOutput("rd_final_addr", 32'(reg_addr), 32'h21);

    w0  = wr_addr_q.size();
    r0  = rd_addr_q.size();
    lo0 = low_cycles;
    b0  = busy_cycles;
    run_range(i_mm, i_wrap);
    checkOutput("mm_sda_low_cycles", 32'(low_cycles - lo0), 32'd0);
    checkOutput("mm_busy_cycles",    32'(busy_cycles - b0), 32'd0);
    checkOutput("mm_writes", 32'(wr_addr_q.size() - w0), 32'd0);
    checkOutput("mm_reads",  32'(rd_addr_q.size() - r0), 32'd0);

    w0 = wr_addr_q.size();
    run_range(i_wrap, i_end);
    checkOutput("wrap_count", 32'(wr_addr_q.size() - w0), 32'd2);
    if (wr_addr_q.size() - w0 == 2) begin
      checkOutput("wrap0_addr", 32'(wr_addr_q[w0]),     32'hFF);
      checkOutput("wrap0_data", 32'(wr_data_q[w0]),     32'h11);
      checkOutput("wrap1_addr", 32'(wr_addr_q[w0 + 1]), 32'h00);
      checkOutput("wrap1_data", 32'(wr_data_q[w0 + 1]), 32'h22);
    end
    checkOutput("wrap_final_addr", 32'(reg_addr), 32'h01);

    // Abort: STOP after four bits of a data byte
    w0 = wr_addr_q.size();
    i2c_start();
    write_byte(8'hA0, s);
    checkOutput("abort_addr_ack", 32'(s), 32'd0);
    write_byte(8'h40, s);
    checkOutput("abort_ptr_ack", 32'(s), 32'd0);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    i2c_stop();
    checkOutput("abort_no_write", 32'(wr_addr_q.size() - w0), 32'd0);
    checkOutput("abort_state",    32'(dut.state), 32'(ST_IDLE));
    checkOutput("abort_ptr",      32'(reg_addr), 32'h40);
    checkOutput("abort_busy",     32'(busy), 32'd0);

    // Reset while the target drives the ACK of a read address
    addr_rd = 8'hA1;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(addr_rd[i], s);
    waited = 0;
    while (sda_drive !== 1'b0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rst_ack_driven", 32'(sda_drive), 32'd0);
    checkOutput("rst_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_sda_drive", 32'(sda_drive), 32'd1);
    checkOutput("rst_reg_addr",  32'(reg_addr),  32'h00);
    checkOutput("rst_reg_wdata", 32'(reg_wdata), 32'h00);
    checkOutput("rst_wr_en",     32'(reg_wr_en), 32'd0);
    checkOutput("rst_rd_en",     32'(reg_rd_en), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_state",     32'(dut.state), 32'(ST_IDLE));
    wait_clk(3);
    rst = 1'b0;
    sda_ctrl = 1'b1;
    wait_clk(Q);
    scl_ctrl = 1'b1;
    wait_clk(3 * Q);
    checkOutput("post_rst_sda_drive", 32'(sda_drive), 32'd1);
    checkOutput("post_rst_state", 32'(dut.state), 32'(ST_IDLE));

    checkOutput("hold_transitions_seen", 32'(hold_seen > 10), 32'd1);
    checkOutput("hold_delay_violations", 32'(hold_bad), 32'd0);
    if (hold_bad != 0) $display("[TB] last bad hold delay=%0d negedges", hold_bad_since);
    checkOutput("hold_scl_high_changes", 32'(hold_high_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
